dcache_port: RTL
================

# dcache_port

Memory-side adapter between the load/store buffer and the byte-wide unified RAM port. It accepts one byte, half-word or word access per request, serialises it into little-endian single-byte RAM transactions, and returns one completion pulse to the load/store buffer. Read data is zero-extended; sign extension belongs to the consumer. A store to the I/O window stalls while the I/O buffer reports full.

## Interface

**Parameters**
- `IO_MASK_HI`, default 2'b11: value of `addr[17:16]` that selects the I/O window.

**Ports**
- `clockIn`  input  1  system clock, rising edge.
- `resetIn`  input  1  asynchronous, active-high reset.
- `clearIn`  input  1  pipeline flush from the reorder buffer (misprediction).
- `accessType`  input  2  request size: 00 none, 01 byte, 10 half word, 11 word. A non-zero value is a request.
- `readWriteIn`  input  1  1 read, 0 write.
- `dataAddr`  input  32  byte address of the first byte.
- `dataOut`  input  32  store data; the low bytes are used.
- `dataValid`  output  1  one-cycle pulse: read complete.
- `dataIn`  output  32  assembled read data, zero-extended.
- `dataWriteSuc`  output  1  one-cycle pulse: write complete.
- `ioBufferFull`  input  1  the I/O buffer cannot take a byte.
- `memIn`  input  8  RAM read byte, valid one cycle after its address is presented.
- `memOut`  output  8  RAM write byte.
- `memAddr`  output  32  RAM byte address.
- `memWrite`  output  1  1 writes `memOut` at the next edge.

## Operation

- **State machine:** IDLE, READ, WRITE.
- **Byte count:** n is 1, 2 or 4 from `accessType`. A 2-bit counter k runs from 0 to n-1.
- **IDLE**
  - Samples the request when `accessType` is not 00.
  - Latches the address, data, n and direction.
  - Clears the assembly register, sets k=0 and moves to READ or WRITE.
  - Requests presented in READ or WRITE are ignored. The bench asserts that none occur.
- **READ**
  - Presents `memAddr`=addr+k with `memWrite`=0.
  - `memIn` for byte k arrives one cycle later and is placed at bits [8k+7:8k].
  - Completing the final byte moves the block to IDLE and pulses `dataValid` with `dataIn`.
- **WRITE**
  - Presents addr+k, `memOut`=data[8k+7:8k] and `memWrite`=1. k advances each cycle.
  - If addr[17:16]==`IO_MASK_HI` and `ioBufferFull`=1, it drives `memWrite`=0 and k holds.
  - The final byte write moves the block to IDLE and pulses `dataWriteSuc`.
- **clearIn**
  - In READ: the block returns to IDLE next edge and emits no `dataValid`.
  - In WRITE: ignored. Committed stores survive a flush and must finish.
  - In IDLE: also blocks sampling a request that edge.
- **Address arithmetic:** 32-bit wrap-around, no alignment check. Misaligned accesses split across bytes naturally.

## Timing

- **Reset values:**
  - state IDLE
  - `memWrite`=0, `memAddr`=0, `memOut`=0
  - `dataValid`=0, `dataWriteSuc`=0, `dataIn`=0
- **Request sampling:** the request is sampled at edge t. Byte k is presented during cycle t+k+1.
- **Read latency:** `dataValid` is high in the cycle after edge t+n+1.
  - Word: 5 cycles.
  - Half word: 3 cycles.
  - Byte: 2 cycles.
- **Write latency:** `dataWriteSuc` is high in the cycle after edge t+n, plus one cycle per I/O stall.
- **Pulse width:** `dataValid` and `dataWriteSuc` are exactly one cycle. `dataIn` holds until the next read completes.
- **Back-to-back:** a new request is accepted at the edge after the completion edge. There is no throughput bubble other than that.
- **Idle outputs:** in IDLE `memWrite`=0 and `memAddr` holds its last value.
- **Reset mid-operation:** the block drops to IDLE at once and emits no completion pulse. A partially written word stays partially written.

## Structure

- **Shared package `lsb_pkg`:**
  - access-type constants ACC_NONE/ACC_BYTE/ACC_HALF/ACC_WORD, also used by the load/store buffer
  - the state enum
  - the IO_MASK_HI default
- **Sub-modules:** none. The block is a single module, and byte steering is inline.

## Test plan

- **Word read:** RAM[0x1000..0x1003]=11,22,33,44. Word read at 0x1000 -> `memAddr` 1000..1003 on consecutive cycles, `dataIn`=0x44332211, `dataValid` one cycle, 5 cycles after the request.
- **Half-word write:** `dataOut`=0x0000ABCD at 0x2002 -> RAM[0x2002]=CD, RAM[0x2003]=AB, `dataWriteSuc` 2 cycles after the request, `memWrite` high exactly 2 cycles.
- **I/O stall:** byte write 0x41 to 0x00030000 with `ioBufferFull`=1 for 3 cycles -> `memWrite` low for 3 cycles, then one write of 0x41, `dataWriteSuc` 4 cycles after the request.
- **Flush during read:**
  - `clearIn` pulsed during byte 2 of a word read -> no `dataValid`, IDLE next cycle.
  - A following byte read at 0x1001 -> returns 0x00000022.
  - `clearIn` during a word write -> all 4 bytes are written and `dataWriteSuc` fires.
- **Reset mid-write:** `resetIn` asserted asynchronously mid-clock during byte 1 of a word write -> `memWrite` drops immediately, with no `dataWriteSuc`. The first post-reset request is accepted normally.

Source files
------------

// File: rtl/lsb_pkg.sv
// Shared load/store-buffer definitions: access-size codes, the data-port state
// encoding, the I/O window default and small byte-lane helpers.
package lsb_pkg;

  localparam logic [1:0] ACC_NONE = 2'b00;
  localparam logic [1:0] ACC_BYTE = 2'b01;
  localparam logic [1:0] ACC_HALF = 2'b10;
  localparam logic [1:0] ACC_WORD = 2'b11;

  localparam logic [1:0] IO_MASK_HI_DEFAULT = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2
  } dport_state_e;

  // Index of the last byte of an access (n-1).
  function automatic logic [1:0] acc_last(input logic [1:0] acc);
    case (acc)
      ACC_HALF: return 2'd1;
      ACC_WORD: return 2'd3;
      default:  return 2'd0;
    endcase
  endfunction

  function automatic logic [7:0] get_byte(input logic [31:0] w, input logic [1:0] idx);
    return w[{idx, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/dcache_port.sv
// Serialises byte/half/word accesses from the load/store buffer into
// little-endian single-byte transactions on the unified RAM port.
module dcache_port
  import lsb_pkg::*;
#(
  parameter logic [1:0] IO_MASK_HI = IO_MASK_HI_DEFAULT
) (
  input  logic        clockIn,
  input  logic        resetIn,
  input  logic        clearIn,
  input  logic [1:0]  accessType,
  input  logic        readWriteIn,
  input  logic [31:0] dataAddr,
  input  logic [31:0] dataOut,
  output logic        dataValid,
  output logic [31:0] dataIn,
  output logic        dataWriteSuc,
  input  logic        ioBufferFull,
  input  logic [7:0]  memIn,
  output logic [7:0]  memOut,
  output logic [31:0] memAddr,
  output logic        memWrite
);

  dport_state_e state_q, state_d;
  logic [1:0]   k_q, k_d;
  logic [1:0]   last_q, last_d;
  logic [1:0]   rx_q, rx_d;
  logic         rx_vld_q, rx_vld_d;
  logic         sent_all_q, sent_all_d;
  logic         is_io_q, is_io_d;
  logic [31:0]  addr_q, addr_d;
  logic [31:0]  data_q, data_d;
  logic [31:0]  asm_q, asm_d;
  logic [31:0]  mem_addr_q, mem_addr_d;
  logic [7:0]   mem_out_q, mem_out_d;
  logic         data_valid_q, data_valid_d;
  logic         write_suc_q, write_suc_d;
  logic [31:0]  data_in_q, data_in_d;
  logic         stall;

  assign stall = is_io_q & ioBufferFull;

  always_comb begin
    // NOTE: every signal assigned here gets a default first so no path can infer a latch.
    state_d      = state_q;
    k_d          = k_q;
    last_d       = last_q;
    rx_d         = rx_q;
    rx_vld_d     = rx_vld_q;
    sent_all_d   = sent_all_q;
    is_io_d      = is_io_q;
    addr_d       = addr_q;
    data_d       = data_q;
    asm_d        = asm_q;
    mem_addr_d   = mem_addr_q;
    mem_out_d    = mem_out_q;
    data_in_d    = data_in_q;
    data_valid_d = 1'b0;
    write_suc_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (!clearIn && accessType != ACC_NONE) begin
          addr_d     = dataAddr;
          data_d     = dataOut;
          last_d     = acc_last(accessType);
          is_io_d    = (dataAddr[17:16] == IO_MASK_HI);
          asm_d      = '0;
          k_d        = 2'd0;
          rx_vld_d   = 1'b0;
          sent_all_d = 1'b0;
          mem_addr_d = dataAddr;
          mem_out_d  = dataOut[7:0];
          state_d    = readWriteIn ? ST_READ : ST_WRITE;
        end
      end

      ST_READ: begin
        if (clearIn) begin
          rx_vld_d = 1'b0;
          state_d  = ST_IDLE;
        end else begin
          // memIn carries the byte whose address was presented last cycle.
          if (rx_vld_q) begin
            asm_d = asm_q | (32'(memIn) << {rx_q, 3'b000});
            if (rx_q == last_q) begin
              data_in_d    = asm_d;
              data_valid_d = 1'b1;
              state_d      = ST_IDLE;
            end
          end
          if (!sent_all_q) begin
            rx_vld_d = 1'b1;
            rx_d     = k_q;
            if (k_q == last_q) begin
              sent_all_d = 1'b1;
            end else begin
              k_d        = k_q + 2'd1;
              mem_addr_d = addr_q + {30'd0, k_d};
            end
          end else begin
            rx_vld_d = 1'b0;
          end
        end
      end

      ST_WRITE: begin
        // Stores are committed, so a flush does not abort them.
        if (!stall) begin
          if (k_q == last_q) begin
            write_suc_d = 1'b1;
            state_d     = ST_IDLE;
          end else begin
            k_d        = k_q + 2'd1;
            mem_addr_d = addr_q + {30'd0, k_d};
            mem_out_d  = get_byte(data_q, k_d);
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state is updated only with non-blocking assignments.
  always_ff @(posedge clockIn or posedge resetIn) begin
    if (resetIn) begin
      state_q      <= ST_IDLE;
      k_q          <= 2'd0;
      last_q       <= 2'd0;
      rx_q         <= 2'd0;
      rx_vld_q     <= 1'b0;
      sent_all_q   <= 1'b0;
      is_io_q      <= 1'b0;
      addr_q       <= '0;
      data_q       <= '0;
      asm_q        <= '0;
      mem_addr_q   <= '0;
      mem_out_q    <= '0;
      data_in_q    <= '0;
      data_valid_q <= 1'b0;
      write_suc_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      k_q          <= k_d;
      last_q       <= last_d;
      rx_q         <= rx_d;
      rx_vld_q     <= rx_vld_d;
      sent_all_q   <= sent_all_d;
      is_io_q      <= is_io_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
      asm_q        <= asm_d;
      mem_addr_q   <= mem_addr_d;
      mem_out_q    <= mem_out_d;
      data_in_q    <= data_in_d;
      data_valid_q <= data_valid_d;
      write_suc_q  <= write_suc_d;
    end
  end

  // Write strobe is combinational so an I/O stall or reset drops it immediately.
  assign memWrite     = (state_q == ST_WRITE) && !stall;
  assign memAddr      = mem_addr_q;
  assign memOut       = mem_out_q;
  assign dataValid    = data_valid_q;
  assign dataWriteSuc = write_suc_q;
  assign dataIn       = data_in_q;

endmodule
